edma_dp2d: RTL and testbench

Parametrised successor DMA datapath with autonomous 2D (inner/outer loop) address and count sequencing.
- Owns its own state machine rather than being stepped externally.
- Emits one emesh packet per beat through a stallable output register.
- Sits between the edma register file/control and the emesh fabric.
- Master mode generates read requests. Slave mode rewrites addresses on incoming write streams.

---
 rtl/edma_dp2d_pkg.sv | 23 ++
 rtl/edma_dp2d_if.sv | 23 ++
 rtl/edma_dp2d_addrgen.sv | 35 +++
 rtl/edma_dp2d.sv | 151 +++++++++++++++
 tb/tb_edma_dp2d.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/edma_dp2d_pkg.sv
// Shared definitions for the 2D DMA datapath: state encoding, emesh packet
// field offsets and the {hi, lo} field selectors of count/stride registers.
package edma_dp2d_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        DONE   = 2'b10
    } state_t;

    // emesh packet: {srcaddr, data, dstaddr, ctrlmode, datamode, write}
    localparam int PKT_WRITE   = 0;
    localparam int PKT_DM_LSB  = 1;
    localparam int PKT_CM_LSB  = 3;
    localparam int PKT_DST_LSB = 8;

    // count_reg = {outer, inner}; stride regs = {dst, src}
    localparam int FLD_INNER = 0;
    localparam int FLD_OUTER = 1;
    localparam int FLD_SRC   = 0;
    localparam int FLD_DST   = 1;

endpackage

// File: rtl/edma_dp2d_if.sv
// emesh stream bundle for the DMA datapath: slave input stream plus the
// registered output stream. The master modport is the DMA side.
interface edma_dp2d_if #(
    parameter int AW = 32,
    parameter int PW = 2*AW+40
);
    logic          access_in;
    logic [PW-1:0] packet_in;
    logic          wait_out;
    logic          access_out;
    logic [PW-1:0] packet_out;
    logic          wait_in;

    modport master (
        input  access_in, packet_in, wait_in,
        output wait_out, access_out, packet_out
    );

    modport slave (
        output access_in, packet_in, wait_in,
        input  wait_out, access_out, packet_out
    );
endinterface

// File: rtl/edma_dp2d_addrgen.sv
// One live address register: load a start value, or step it by a
// sign-extended inner or outer stride (outer wins), wrapping modulo 2^AW.
module edma_dp2d_addrgen #(
    parameter int AW = 32,
    parameter int SW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic          step_inner,
    input  logic          step_outer,
    input  logic [SW-1:0] stride_inner,
    input  logic [SW-1:0] stride_outer,
    output logic [AW-1:0] addr
);

    logic [AW-1:0] inc_inner;
    logic [AW-1:0] inc_outer;

    assign inc_inner = {{(AW-SW){stride_inner[SW-1]}}, stride_inner};
    assign inc_outer = {{(AW-SW){stride_outer[SW-1]}}, stride_outer};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            addr <= '0;
        else if (load)
            addr <= load_addr;
        else if (step_outer)
            addr <= addr + inc_outer;
        else if (step_inner)
            addr <= addr + inc_inner;
    end

endmodule

// File: rtl/edma_dp2d.sv
// Autonomous 2D DMA datapath: walks inner/outer loop counts and addresses,
// emitting one emesh packet per beat through a stallable output register.
module edma_dp2d
    import edma_dp2d_pkg::*;
#(
    parameter int AW = 32,
    parameter int PW = 2*AW+40,
    parameter int CW = 16,
    parameter int SW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stop,
    input  logic            master_active,
    input  logic [1:0]      datamode,
    input  logic [4:0]      ctrlmode,
    input  logic [2*CW-1:0] count_reg,
    input  logic [2*SW-1:0] stride_reg,
    input  logic [2*SW-1:0] stride2d_reg,
    input  logic [AW-1:0]   srcaddr_reg,
    input  logic [AW-1:0]   dstaddr_reg,
    edma_dp2d_if.master     bus,
    output logic            busy,
    output logic            done,
    output logic [2*CW-1:0] count,
    output logic [AW-1:0]   srcaddr,
    output logic [AW-1:0]   dstaddr
);

    localparam int DW = PW - 8 - 2*AW;

    state_t        state_q, state_d;
    logic [CW-1:0] inner_q, outer_q;
    logic [CW-1:0] inner_cfg, outer_cfg;
    logic          load, beat, step_inner, step_outer;
    logic [PW-1:0] beat_pkt;

    assign inner_cfg = count_reg[FLD_INNER*CW +: CW];
    assign outer_cfg = count_reg[FLD_OUTER*CW +: CW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        beat       = 1'b0;
        step_inner = 1'b0;
        step_outer = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    load    = 1'b1;
                    state_d = (inner_cfg == '0 || outer_cfg == '0) ? DONE : ACTIVE;
                end
            end
            ACTIVE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (!bus.wait_in && (master_active || bus.access_in)) begin
                    beat = 1'b1;
                    if (inner_q > CW'(1))
                        step_inner = 1'b1;
                    else if (outer_q > CW'(1))
                        step_outer = 1'b1;
                    else
                        state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inner_q <= '0;
            outer_q <= '0;
        end else if (load) begin
            inner_q <= inner_cfg;
            outer_q <= outer_cfg;
        end else if (step_inner) begin
            inner_q <= inner_q - CW'(1);
        end else if (step_outer) begin
            outer_q <= outer_q - CW'(1);
            inner_q <= inner_cfg;
        end
    end

    edma_dp2d_addrgen #(.AW(AW), .SW(SW)) u_src (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .load_addr    (srcaddr_reg),
        .step_inner   (step_inner),
        .step_outer   (step_outer),
        .stride_inner (stride_reg[FLD_SRC*SW +: SW]),
        .stride_outer (stride2d_reg[FLD_SRC*SW +: SW]),
        .addr         (srcaddr)
    );

    edma_dp2d_addrgen #(.AW(AW), .SW(SW)) u_dst (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .load_addr    (dstaddr_reg),
        .step_inner   (step_inner),
        .step_outer   (step_outer),
        .stride_inner (stride_reg[FLD_DST*SW +: SW]),
        .stride_outer (stride2d_reg[FLD_DST*SW +: SW]),
        .addr         (dstaddr)
    );

    // Master reads target srcaddr and name dstaddr as return address;
    // slave writes keep the incoming packet and only retarget dstaddr.
    always_comb begin
        beat_pkt = '0;
        if (master_active) begin
            beat_pkt[PKT_WRITE]                  = 1'b0;
            beat_pkt[PKT_DM_LSB +: 2]            = datamode;
            beat_pkt[PKT_CM_LSB +: 5]            = ctrlmode;
            beat_pkt[PKT_DST_LSB +: AW]          = srcaddr;
            beat_pkt[PKT_DST_LSB+AW+DW +: AW]    = dstaddr;
        end else begin
            beat_pkt                             = bus.packet_in;
            beat_pkt[PKT_WRITE]                  = 1'b1;
            beat_pkt[PKT_DST_LSB +: AW]          = dstaddr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.access_out <= 1'b0;
            bus.packet_out <= '0;
        end else if (!bus.wait_in) begin
            bus.access_out <= beat;
            bus.packet_out <= beat_pkt;
        end
    end

    assign bus.wait_out = bus.wait_in | ~(state_q == ACTIVE & ~master_active);
    assign busy         = (state_q == ACTIVE);
    assign done         = (state_q == DONE);
    assign count        = {outer_q, inner_q};

endmodule

// File: tb/tb_edma_dp2d.sv
// Directed bench for edma_dp2d: table of master-mode transfers plus
// hand sequences for backpressure, slave rewrite, zero count, stop and reset.
module tb_edma_dp2d;

    localparam int AW = 32;
    localparam int PW = 104;
    localparam int CW = 16;
    localparam int SW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            start, stop, master_active;
    logic [1:0]      datamode;
    logic [4:0]      ctrlmode;
    logic [2*CW-1:0] count_reg;
    logic [2*SW-1:0] stride_reg, stride2d_reg;
    logic [AW-1:0]   srcaddr_reg, dstaddr_reg;
    logic            busy, done;
    logic [2*CW-1:0] count;
    logic [AW-1:0]   srcaddr, dstaddr;

    edma_dp2d_if #(.AW(AW), .PW(PW)) bus ();

    edma_dp2d #(.AW(AW), .PW(PW), .CW(CW), .SW(SW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .master_active (master_active),
        .datamode      (datamode),
        .ctrlmode      (ctrlmode),
        .count_reg     (count_reg),
        .stride_reg    (stride_reg),
        .stride2d_reg  (stride2d_reg),
        .srcaddr_reg   (srcaddr_reg),
        .dstaddr_reg   (dstaddr_reg),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .count         (count),
        .srcaddr       (srcaddr),
        .dstaddr       (dstaddr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] mkpkt(input logic [31:0] src, input logic [31:0] data,
                                            input logic [31:0] dst, input logic [4:0] cm,
                                            input logic [1:0] dm, input logic wr);
        return {src, data, dst, cm, dm, wr};
    endfunction

    typedef struct {
        logic [31:0]      cnt, st, st2, src, dst;
        logic [1:0]       dm;
        logic [4:0]       cm;
        int               nbeats;
        logic [7:0][31:0] exp_rd;
        logic [7:0][31:0] exp_ret;
    } vec_t;

    vec_t vecs[4];

    int          k, ndone, done_t, ng;
    logic        seen_acc, was_wait, snap_acc;
    logic [PW-1:0]   snap_pkt;
    logic [2*CW-1:0] snap_cnt;
    logic [31:0]     got_addr[16];
    logic [PW-1:0]   got_pkt[16];

    initial begin
        vecs[0].cnt = 32'h0001_0004; vecs[0].st = 32'h0010_0004; vecs[0].st2 = 32'h0;
        vecs[0].src = 32'h1000; vecs[0].dst = 32'h5000; vecs[0].dm = 2'd2; vecs[0].cm = 5'h05;
        vecs[0].nbeats = 4; vecs[0].exp_rd = '0; vecs[0].exp_ret = '0;
        vecs[0].exp_rd[0] = 32'h1000; vecs[0].exp_rd[1] = 32'h1004;
        vecs[0].exp_rd[2] = 32'h1008; vecs[0].exp_rd[3] = 32'h100C;
        vecs[0].exp_ret[0] = 32'h5000; vecs[0].exp_ret[1] = 32'h5010;
        vecs[0].exp_ret[2] = 32'h5020; vecs[0].exp_ret[3] = 32'h5030;

        vecs[1].cnt = 32'h0003_0002; vecs[1].st = 32'h0001_0008; vecs[1].st2 = 32'h0040_0100;
        vecs[1].src = 32'h0; vecs[1].dst = 32'h8000; vecs[1].dm = 2'd1; vecs[1].cm = 5'h1F;
        vecs[1].nbeats = 6; vecs[1].exp_rd = '0; vecs[1].exp_ret = '0;
        vecs[1].exp_rd[0] = 32'h000; vecs[1].exp_rd[1] = 32'h008; vecs[1].exp_rd[2] = 32'h108;
        vecs[1].exp_rd[3] = 32'h110; vecs[1].exp_rd[4] = 32'h210; vecs[1].exp_rd[5] = 32'h218;
        vecs[1].exp_ret[0] = 32'h8000; vecs[1].exp_ret[1] = 32'h8001; vecs[1].exp_ret[2] = 32'h8041;
        vecs[1].exp_ret[3] = 32'h8042; vecs[1].exp_ret[4] = 32'h8082; vecs[1].exp_ret[5] = 32'h8083;

        // negative strides wrap below zero; 0x7FFF must stay positive
        vecs[2].cnt = 32'h0002_0002; vecs[2].st = 32'h0002_FFFC; vecs[2].st2 = 32'h7FFF_FFF0;
        vecs[2].src = 32'h4; vecs[2].dst = 32'h0; vecs[2].dm = 2'd0; vecs[2].cm = 5'h00;
        vecs[2].nbeats = 4; vecs[2].exp_rd = '0; vecs[2].exp_ret = '0;
        vecs[2].exp_rd[0] = 32'h4; vecs[2].exp_rd[1] = 32'h0;
        vecs[2].exp_rd[2] = 32'hFFFF_FFF0; vecs[2].exp_rd[3] = 32'hFFFF_FFEC;
        vecs[2].exp_ret[0] = 32'h0; vecs[2].exp_ret[1] = 32'h2;
        vecs[2].exp_ret[2] = 32'h8001; vecs[2].exp_ret[3] = 32'h8003;

        vecs[3].cnt = 32'h0001_0001; vecs[3].st = 32'h1111_1111; vecs[3].st2 = 32'h2222_2222;
        vecs[3].src = 32'hFFFF_FFFC; vecs[3].dst = 32'h1234; vecs[3].dm = 2'd3; vecs[3].cm = 5'h0A;
        vecs[3].nbeats = 1; vecs[3].exp_rd = '0; vecs[3].exp_ret = '0;
        vecs[3].exp_rd[0] = 32'hFFFF_FFFC; vecs[3].exp_ret[0] = 32'h1234;

        reset = 1'b1; start = 1'b0; stop = 1'b0; master_active = 1'b1;
        datamode = '0; ctrlmode = '0; count_reg = '0; stride_reg = '0; stride2d_reg = '0;
        srcaddr_reg = '0; dstaddr_reg = '0;
        bus.access_in = 1'b0; bus.packet_in = '0; bus.wait_in = 1'b0;
        tick(); tick();
        check("rst_access_out", bus.access_out, 0);
        check("rst_packet_out", bus.packet_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        check("rst_srcaddr", srcaddr, 0);
        check("rst_dstaddr", dstaddr, 0);
        check("rst_wait_out", bus.wait_out, 1);
        reset = 1'b0;
        tick();

        // ---------------- master table ----------------
        for (int v = 0; v < 4; v++) begin
            count_reg = vecs[v].cnt; stride_reg = vecs[v].st; stride2d_reg = vecs[v].st2;
            srcaddr_reg = vecs[v].src; dstaddr_reg = vecs[v].dst;
            datamode = vecs[v].dm; ctrlmode = vecs[v].cm; master_active = 1'b1;
            start = 1'b1; tick(); start = 1'b0;
            k = 0; ndone = 0; done_t = -1;
            for (int t = 1; t <= 12; t++) begin
                check("m_busy", busy, (t <= vecs[v].nbeats));
                if (bus.access_out) begin
                    if (k < 8) begin
                        check("m_rd_addr", bus.packet_out[39:8], vecs[v].exp_rd[k]);
                        check("m_ret_addr", bus.packet_out[103:72], vecs[v].exp_ret[k]);
                        check("m_beat_cycle", t, k + 2);
                    end
                    check("m_hdr", bus.packet_out[7:0], {vecs[v].cm, vecs[v].dm, 1'b0});
                    check("m_data", bus.packet_out[71:40], 0);
                    k++;
                end
                if (done) begin ndone++; done_t = t; end
                tick();
            end
            check("m_nbeats", k, vecs[v].nbeats);
            check("m_ndone", ndone, 1);
            check("m_done_cycle", done_t, vecs[v].nbeats + 1);
            check("m_final_count", count, 32'h0001_0001);
            check("m_final_src", srcaddr, vecs[v].exp_rd[vecs[v].nbeats-1]);
            check("m_final_dst", dstaddr, vecs[v].exp_ret[vecs[v].nbeats-1]);
        end

        // ---------------- backpressure ----------------
        count_reg = 32'h0001_0006; stride_reg = 32'h0000_0001; stride2d_reg = '0;
        srcaddr_reg = 32'h300; dstaddr_reg = 32'h0;
        start = 1'b1; tick(); start = 1'b0;
        ng = 0; ndone = 0;
        for (int t = 1; t <= 20; t++) begin
            bus.wait_in = (t >= 3 && t <= 5);
            if (bus.access_out && !bus.wait_in && ng < 16) begin
                got_addr[ng] = bus.packet_out[39:8];
                ng++;
            end
            if (done) ndone++;
            snap_pkt = bus.packet_out; snap_acc = bus.access_out; snap_cnt = count;
            was_wait = bus.wait_in;
            tick();
            if (was_wait) begin
                check("bp_frozen_acc", bus.access_out, snap_acc);
                check("bp_frozen_pkt", bus.packet_out, snap_pkt);
                check("bp_frozen_cnt", count, snap_cnt);
            end
        end
        bus.wait_in = 1'b0;
        check("bp_ngot", ng, 6);
        for (int i = 0; i < 6; i++)
            if (i < ng) check("bp_addr", got_addr[i], 32'h300 + i);
        check("bp_ndone", ndone, 1);

        // ---------------- slave rewrite ----------------
        master_active = 1'b0;
        count_reg = 32'h0001_0003; stride_reg = 32'hFFFC_0000; stride2d_reg = '0;
        srcaddr_reg = '0; dstaddr_reg = 32'h2000;
        check("sl_wait_idle", bus.wait_out, 1);
        start = 1'b1; tick(); start = 1'b0;
        check("sl_wait_active", bus.wait_out, 0);
        ng = 0; ndone = 0;
        for (int t = 1; t <= 10; t++) begin
            bus.access_in = 1'b0;
            if (t == 1) begin bus.access_in = 1'b1; bus.packet_in = mkpkt(32'h77, 32'hA, 32'hDEAD, 5'h11, 2'd2, 1'b0); end
            if (t == 3) begin bus.access_in = 1'b1; bus.packet_in = mkpkt(32'h78, 32'hB, 32'hDEAD, 5'h11, 2'd2, 1'b0); end
            if (t == 4) begin bus.access_in = 1'b1; bus.packet_in = mkpkt(32'h79, 32'hC, 32'hDEAD, 5'h11, 2'd2, 1'b0); end
            if (bus.access_out && ng < 16) begin
                got_pkt[ng] = bus.packet_out;
                ng++;
            end
            if (done) ndone++;
            tick();
        end
        bus.access_in = 1'b0;
        check("sl_ngot", ng, 3);
        if (ng > 0) check("sl_pkt0", got_pkt[0], mkpkt(32'h77, 32'hA, 32'h2000, 5'h11, 2'd2, 1'b1));
        if (ng > 1) check("sl_pkt1", got_pkt[1], mkpkt(32'h78, 32'hB, 32'h1FFC, 5'h11, 2'd2, 1'b1));
        if (ng > 2) check("sl_pkt2", got_pkt[2], mkpkt(32'h79, 32'hC, 32'h1FF8, 5'h11, 2'd2, 1'b1));
        check("sl_ndone", ndone, 1);
        check("sl_wait_after", bus.wait_out, 1);

        // ---------------- zero count ----------------
        master_active = 1'b1;
        count_reg = 32'h0000_0005; stride_reg = 32'h0000_0004; srcaddr_reg = 32'h100;
        start = 1'b1; tick(); start = 1'b0;
        check("z_done", done, 1);
        check("z_busy", busy, 0);
        check("z_count", count, 32'h0000_0005);
        seen_acc = bus.access_out;
        tick();
        check("z_done_gone", done, 0);
        for (int t = 0; t < 5; t++) begin
            seen_acc = seen_acc | bus.access_out;
            tick();
        end
        check("z_no_access", seen_acc, 0);

        // ---------------- stop ----------------
        count_reg = 32'h0001_0008; stride_reg = 32'h0000_0004; srcaddr_reg = 32'h4000;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        check("ab_beat1", bus.access_out, 1);
        stop = 1'b1; tick(); stop = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_no_beat", bus.access_out, 0);
        check("ab_count", count, 32'h0001_0007);
        check("ab_src", srcaddr, 32'h4004);
        seen_acc = 1'b0; ndone = 0;
        for (int t = 0; t < 4; t++) begin
            seen_acc = seen_acc | bus.access_out;
            if (done) ndone++;
            tick();
        end
        check("ab_no_done", ndone, 0);
        check("ab_quiet", seen_acc, 0);

        // ---------------- async reset mid-transfer ----------------
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        check("rs_pre_access", bus.access_out, 1);
        #2 reset = 1'b1;
        #1;
        check("rs_access_out", bus.access_out, 0);
        check("rs_packet_out", bus.packet_out, 0);
        check("rs_busy", busy, 0);
        check("rs_count", count, 0);
        check("rs_srcaddr", srcaddr, 0);
        check("rs_dstaddr", dstaddr, 0);
        tick();
        reset = 1'b0;
        tick();
        check("rs_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
